// File: rtl/bcd_key_entry_ctrl_pkg.sv
// Shared definitions for the keypad-to-BCD entry controller.
package bcd_key_entry_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        DEBOUNCE     = 2'd1,
        CAPTURE      = 2'd2,
        WAIT_RELEASE = 2'd3
    } state_t;

    localparam int BCD_W = 4;
    localparam int NKEYS = 10;

endpackage

// File: rtl/bcd_key_entry_ctrl_enc.sv
// Ten-line one-hot to BCD encoder; o_single flags exactly one active key.
module bcd_onehot_enc
    import bcd_key_entry_ctrl_pkg::*;
(
    input  logic [NKEYS-1:0] i_key,
    output logic [BCD_W-1:0] o_code,
    output logic             o_single
);

    logic [BCD_W-1:0] w_code;
    logic [3:0]       w_ones;

    // OR of active indices equals the index itself for any one-hot input.
    always_comb begin
        w_code = '0;
        w_ones = '0;
        for (int i = 0; i < NKEYS; i++) begin
            if (i_key[i]) begin
                w_code = w_code | BCD_W'(i);
                w_ones = w_ones + 4'd1;
            end
        end
    end

    assign o_code   = w_code;
    assign o_single = (w_ones == 4'd1);

endmodule

// File: rtl/bcd_key_entry_ctrl.sv
// Debounces ten decimal key lines and shifts each accepted digit into a
// multi-digit BCD entry register, with overflow and multi-key reporting.
module bcd_key_entry_ctrl
    import bcd_key_entry_ctrl_pkg::*;
#(
    parameter  int DEBOUNCE_CYCLES = 4,
    parameter  int NDIGITS         = 4,
    localparam int CNT_W           = $clog2(NDIGITS + 1)
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [NKEYS-1:0]         KEY,
    input  logic                     CLR,
    output logic [BCD_W-1:0]         DIGIT,
    output logic                     DIGIT_VALID,
    output logic [BCD_W*NDIGITS-1:0] DIGITS,
    output logic [CNT_W-1:0]         COUNT,
    output logic                     FULL,
    output logic                     DROP,
    output logic                     MULTI_ERR
);

    localparam int               DW       = BCD_W * NDIGITS;
    localparam logic [7:0]       DC8      = 8'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NDIGITS);

    state_t            r_state;
    logic [NKEYS-1:0]  r_sample;
    logic [7:0]        r_cnt;
    logic [BCD_W-1:0]  r_digit;
    logic              r_digit_valid;
    logic [DW-1:0]     r_digits;
    logic [CNT_W-1:0]  r_count;
    logic              r_full;
    logic              r_drop;
    logic              r_multi_err;

    logic              w_key_nz;
    logic [7:0]        w_cnt_inc;
    logic [NKEYS-1:0]  w_sample_nxt;
    logic              w_go_capture;
    logic [BCD_W-1:0]  w_code;
    logic              w_single;
    logic [DW-1:0]     w_digits_shifted;
    logic [CNT_W-1:0]  w_count_inc;

    assign w_key_nz    = |KEY;
    assign w_cnt_inc   = r_cnt + 8'd1;
    assign w_count_inc = r_count + CNT_W'(1);

    // The encoder looks at the pattern being latched this edge, so the strobe
    // lands in the same cycle the FSM sits in CAPTURE.
    assign w_sample_nxt = ((r_state == IDLE || r_state == DEBOUNCE) && w_key_nz)
                          ? KEY : r_sample;

    assign w_go_capture =
        ((r_state == IDLE) && w_key_nz && (DEBOUNCE_CYCLES == 1)) ||
        ((r_state == DEBOUNCE) && w_key_nz && (KEY == r_sample) && (w_cnt_inc == DC8));

    assign w_digits_shifted = (r_digits << BCD_W) | DW'(w_code);

    bcd_onehot_enc u_enc (
        .i_key    (w_sample_nxt),
        .o_code   (w_code),
        .o_single (w_single)
    );

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state       <= IDLE;
            r_sample      <= '0;
            r_cnt         <= '0;
            r_digit       <= '0;
            r_digit_valid <= 1'b0;
            r_digits      <= '0;
            r_count       <= '0;
            r_full        <= 1'b0;
            r_drop        <= 1'b0;
            r_multi_err   <= 1'b0;
        end else begin
            r_digit_valid <= 1'b0;
            r_drop        <= 1'b0;
            r_multi_err   <= 1'b0;
            r_sample      <= w_sample_nxt;

            case (r_state)
                IDLE: begin
                    if (w_key_nz) begin
                        r_cnt   <= 8'd1;
                        r_state <= (DEBOUNCE_CYCLES == 1) ? CAPTURE : DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (!w_key_nz) begin
                        r_cnt   <= '0;
                        r_state <= IDLE;
                    end else if (KEY == r_sample) begin
                        r_cnt <= w_cnt_inc;
                        if (w_cnt_inc == DC8) begin
                            r_state <= CAPTURE;
                        end
                    end else begin
                        r_cnt <= 8'd1;
                    end
                end
                CAPTURE: begin
                    r_cnt   <= '0;
                    r_state <= WAIT_RELEASE;
                end
                WAIT_RELEASE: begin
                    if (w_key_nz) begin
                        r_cnt <= '0;
                    end else if (w_cnt_inc == DC8) begin
                        r_cnt   <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= IDLE;
                end
            endcase

            if (w_go_capture) begin
                if (!w_single) begin
                    r_multi_err <= 1'b1;
                end else if (!CLR) begin
                    if (r_full) begin
                        r_drop <= 1'b1;
                    end else begin
                        r_digits      <= w_digits_shifted;
                        r_count       <= w_count_inc;
                        r_full        <= (w_count_inc == FULL_CNT);
                        r_digit       <= w_code;
                        r_digit_valid <= 1'b1;
                    end
                end
            end

            // Clear overrides any shift decided in the same cycle.
            if (CLR) begin
                r_digits <= '0;
                r_count  <= '0;
                r_full   <= 1'b0;
            end
        end
    end

    assign DIGIT       = r_digit;
    assign DIGIT_VALID = r_digit_valid;
    assign DIGITS      = r_digits;
    assign COUNT       = r_count;
    assign FULL        = r_full;
    assign DROP        = r_drop;
    assign MULTI_ERR   = r_multi_err;

endmodule

// File: tb/tb_bcd_key_entry_ctrl.sv
// Directed bench for bcd_key_entry_ctrl with default parameters (4 / 4).
module tb_bcd_key_entry_ctrl;

    logic        CLK;
    logic        RST;
    logic [9:0]  KEY;
    logic        CLR;
    logic [3:0]  DIGIT;
    logic        DIGIT_VALID;
    logic [15:0] DIGITS;
    logic [2:0]  COUNT;
    logic        FULL;
    logic        DROP;
    logic        MULTI_ERR;

    int checks   = 0;
    int errors   = 0;
    int tick_no  = 0;
    int dv_cnt   = 0;
    int first_dv = 0;
    int drop_cnt = 0;
    int merr_cnt = 0;

    bcd_key_entry_ctrl #(.DEBOUNCE_CYCLES(4), .NDIGITS(4)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .KEY         (KEY),
        .CLR         (CLR),
        .DIGIT       (DIGIT),
        .DIGIT_VALID (DIGIT_VALID),
        .DIGITS      (DIGITS),
        .COUNT       (COUNT),
        .FULL        (FULL),
        .DROP        (DROP),
        .MULTI_ERR   (MULTI_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic clear_mon();
        tick_no  = 0;
        dv_cnt   = 0;
        first_dv = 0;
        drop_cnt = 0;
        merr_cnt = 0;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
        tick_no++;
        if (DIGIT_VALID) begin
            dv_cnt++;
            if (first_dv == 0) first_dv = tick_no;
        end
        if (DROP)      drop_cnt++;
        if (MULTI_ERR) merr_cnt++;
    endtask

    task automatic press(input logic [9:0] k, input int hold, input int rel);
        KEY = k;
        repeat (hold) step();
        KEY = '0;
        repeat (rel) step();
    endtask

    task automatic test_reset();
        RST = 1'b0; KEY = 10'h3FF; CLR = 1'b0;
        step(); step();
        checks++;
        if ({DIGIT, DIGIT_VALID, DIGITS, COUNT, FULL, DROP, MULTI_ERR} !== 28'd0) begin
            errors++;
            $display("FAIL reset_outputs got DIGIT=%h DV=%b DIGITS=%h COUNT=%0d FULL=%b DROP=%b MERR=%b expected all 0",
                     DIGIT, DIGIT_VALID, DIGITS, COUNT, FULL, DROP, MULTI_ERR);
        end
        RST = 1'b1; KEY = '0;
        clear_mon();
        repeat (3) step();
        checks++;
        if ({DIGIT, DIGIT_VALID, DIGITS, COUNT, FULL, DROP, MULTI_ERR} !== 28'd0 || dv_cnt != 0) begin
            errors++;
            $display("FAIL reset_release got DIGITS=%h COUNT=%0d dv=%0d expected 0", DIGITS, COUNT, dv_cnt);
        end
    endtask

    task automatic test_single_press();
        clear_mon();
        press(10'b1 << 7, 10, 6);
        checks++;
        if (dv_cnt != 1) begin
            errors++;
            $display("FAIL single_dv_count got %0d expected 1", dv_cnt);
        end
        checks++;
        if (first_dv != 4) begin
            errors++;
            $display("FAIL single_latency got tick %0d expected 4", first_dv);
        end
        checks++;
        if (DIGIT !== 4'd7 || DIGITS[3:0] !== 4'd7 || COUNT !== 3'd1) begin
            errors++;
            $display("FAIL single_value got DIGIT=%0d DIGITS=%h COUNT=%0d expected 7/0007/1", DIGIT, DIGITS, COUNT);
        end
    endtask

    task automatic test_bounce();
        logic [9:0] pat [5];
        pat[0] = 10'b1 << 3; pat[1] = '0; pat[2] = 10'b1 << 3; pat[3] = 10'b1 << 3; pat[4] = '0;
        clear_mon();
        for (int i = 0; i < 5; i++) begin
            KEY = pat[i];
            step();
        end
        checks++;
        if (dv_cnt != 0) begin
            errors++;
            $display("FAIL bounce_no_strobe got %0d strobes expected 0", dv_cnt);
        end
        press(10'b1 << 3, 6, 6);
        checks++;
        if (dv_cnt != 1 || DIGIT !== 4'd3) begin
            errors++;
            $display("FAIL bounce_accept got dv=%0d DIGIT=%0d expected 1/3", dv_cnt, DIGIT);
        end
        checks++;
        if (DIGITS !== 16'h0073 || COUNT !== 3'd2) begin
            errors++;
            $display("FAIL bounce_register got DIGITS=%h COUNT=%0d expected 0073/2", DIGITS, COUNT);
        end
    endtask

    task automatic test_multi_key();
        clear_mon();
        press((10'b1 << 2) | (10'b1 << 5), 6, 6);
        checks++;
        if (merr_cnt != 1 || dv_cnt != 0 || COUNT !== 3'd2) begin
            errors++;
            $display("FAIL multi_err got merr=%0d dv=%0d COUNT=%0d expected 1/0/2", merr_cnt, dv_cnt, COUNT);
        end
        clear_mon();
        press(10'b1 << 5, 6, 6);
        checks++;
        if (dv_cnt != 1 || DIGIT !== 4'd5 || DIGITS !== 16'h0735 || COUNT !== 3'd3) begin
            errors++;
            $display("FAIL multi_after got dv=%0d DIGIT=%0d DIGITS=%h COUNT=%0d expected 1/5/0735/3",
                     dv_cnt, DIGIT, DIGITS, COUNT);
        end
    endtask

    task automatic test_fill_overflow();
        CLR = 1'b1;
        step();
        CLR = 1'b0;
        checks++;
        if (DIGITS !== 16'h0000 || COUNT !== 3'd0 || FULL !== 1'b0) begin
            errors++;
            $display("FAIL clr_idle got DIGITS=%h COUNT=%0d FULL=%b expected 0", DIGITS, COUNT, FULL);
        end
        clear_mon();
        for (int d = 1; d <= 4; d++) press(10'b1 << d, 6, 6);
        checks++;
        if (DIGITS !== 16'h1234 || COUNT !== 3'd4 || FULL !== 1'b1 || dv_cnt != 4) begin
            errors++;
            $display("FAIL fill got DIGITS=%h COUNT=%0d FULL=%b dv=%0d expected 1234/4/1/4",
                     DIGITS, COUNT, FULL, dv_cnt);
        end
        clear_mon();
        press(10'b1 << 9, 6, 6);
        checks++;
        if (drop_cnt != 1 || dv_cnt != 0 || DIGITS !== 16'h1234 || DIGIT !== 4'd4) begin
            errors++;
            $display("FAIL overflow_drop got drop=%0d dv=%0d DIGITS=%h DIGIT=%0d expected 1/0/1234/4",
                     drop_cnt, dv_cnt, DIGITS, DIGIT);
        end
        clear_mon();
        KEY = 10'b1 << 8;
        repeat (3) step();
        CLR = 1'b1;
        step();
        CLR = 1'b0;
        checks++;
        if (DIGIT_VALID !== 1'b0 || DROP !== 1'b0 || DIGITS !== 16'h0000 || COUNT !== 3'd0 || FULL !== 1'b0) begin
            errors++;
            $display("FAIL clr_capture got DV=%b DROP=%b DIGITS=%h COUNT=%0d FULL=%b expected 0",
                     DIGIT_VALID, DROP, DIGITS, COUNT, FULL);
        end
        repeat (3) step();
        KEY = '0;
        repeat (6) step();
        checks++;
        if (dv_cnt != 0 || drop_cnt != 0 || COUNT !== 3'd0) begin
            errors++;
            $display("FAIL clr_capture_after got dv=%0d drop=%0d COUNT=%0d expected 0/0/0", dv_cnt, drop_cnt, COUNT);
        end
    endtask

    task automatic test_held_and_reset();
        clear_mon();
        press(10'b1, 50, 6);
        checks++;
        if (dv_cnt != 1 || DIGIT !== 4'd0 || COUNT !== 3'd1 || DIGITS !== 16'h0000) begin
            errors++;
            $display("FAIL held_key got dv=%0d DIGIT=%0d COUNT=%0d DIGITS=%h expected 1/0/1/0000",
                     dv_cnt, DIGIT, COUNT, DIGITS);
        end
        clear_mon();
        KEY = 10'b1 << 6;
        step(); step();
        RST = 1'b0;
        step();
        checks++;
        if ({DIGIT, DIGIT_VALID, DIGITS, COUNT, FULL, DROP, MULTI_ERR} !== 28'd0) begin
            errors++;
            $display("FAIL reset_mid got DIGIT=%0d DV=%b DIGITS=%h COUNT=%0d expected all 0",
                     DIGIT, DIGIT_VALID, DIGITS, COUNT);
        end
        RST = 1'b1;
        KEY = '0;
        repeat (6) step();
        checks++;
        if (dv_cnt != 0 || COUNT !== 3'd0 || DIGIT !== 4'd0) begin
            errors++;
            $display("FAIL reset_mid_after got dv=%0d COUNT=%0d DIGIT=%0d expected 0", dv_cnt, COUNT, DIGIT);
        end
    endtask

    initial begin
        RST = 1'b0;
        KEY = '0;
        CLR = 1'b0;
        test_reset();
        test_single_press();
        test_bounce();
        test_multi_key();
        test_fill_overflow();
        test_held_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
